// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, frame length and line idle level shared by UART TX/RX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned FRAME_BITS = 8;
  localparam logic        LINE_IDLE  = 1'b1;

  // 2-of-3 vote across a short sample history
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the async UART line, reset to the idle level.
// With UART_RX_MAJORITY_EN defined it also exposes the last three synchronized samples.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
`ifdef UART_RX_MAJORITY_EN
  output logic [2:0] o_rx_hist,
`endif
  output logic       o_rx_s
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= LINE_IDLE;
      r_s2 <= LINE_IDLE;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  assign o_rx_s = r_s2;

`ifdef UART_RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  // Delayed copies so the vote at count N sees the samples at N-2, N-1 and N
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h1 <= LINE_IDLE;
      r_h2 <= LINE_IDLE;
    end else begin
      r_h1 <= r_s2;
      r_h2 <= r_h1;
    end
  end

  assign o_rx_hist = {r_h2, r_h1, r_s2};
`endif

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver delivering each good byte as a one-cycle valid pulse.
// Define UART_RX_MAJORITY_EN to vote 2-of-3 around every sample point.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_SPEED = 100_000_000,
  parameter int unsigned BAUD_RATE = 625000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_serial_in,
  output logic [FRAME_BITS-1:0] o_data_out,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  // COUNT_DIV must stay within 4..1024 for the 10-bit bit-timer
  localparam int unsigned COUNT_DIV = CLK_SPEED / BAUD_RATE;
  localparam int unsigned HALF_DIV  = COUNT_DIV / 2;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned IDX_W     = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COUNT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);

  uart_state_e           r_state;
  uart_state_e           w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [IDX_W-1:0]      w_bit_idx_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic                  r_armed;
  logic                  w_armed_nxt;
  logic [FRAME_BITS-1:0] r_data_out;
  logic [FRAME_BITS-1:0] w_data_out_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_frame_err;
  logic                  w_frame_err_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;

  logic w_rx_s;
  logic w_sample;
  logic w_cnt_last;
  logic w_half_last;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] w_rx_hist;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (i_serial_in),
    .o_rx_hist (w_rx_hist),
    .o_rx_s    (w_rx_s)
  );

  assign w_sample = maj3(w_rx_hist);
`else
  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (i_serial_in),
    .o_rx_s (w_rx_s)
  );

  assign w_sample = w_rx_s;
`endif

  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_half_last = (r_cnt == HALF_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (r_armed && !w_rx_s) w_state_nxt = START;
      START: if (w_half_last) w_state_nxt = w_sample ? IDLE : DATA;
      DATA:  if (w_cnt_last && (r_bit_idx == IDX_LAST)) w_state_nxt = STOP;
      STOP:  if (w_cnt_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_armed_nxt     = r_armed;
    w_data_out_nxt  = r_data_out;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_busy_nxt      = (w_state_nxt != IDLE);
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_armed_nxt = 1'b1;
      end
      START: begin
        if (w_half_last) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {w_sample, r_shift[FRAME_BITS-1:1]};
          w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (w_sample) begin
            w_data_out_nxt = r_shift;
            w_valid_nxt    = 1'b1;
          end else begin
            // Disarm so a held-low break reports only once
            w_frame_err_nxt = 1'b1;
            w_armed_nxt     = 1'b0;
          end
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_armed     <= 1'b0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_armed     <= w_armed_nxt;
      r_data_out  <= w_data_out_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_data_out  = r_data_out;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a cycle-stamped scoreboard of expected pulses.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int BIT_CYC   = 160;
  localparam int FRAME_CYC = 10 * BIT_CYC;
  localparam int LAT       = 2 + 80 + 9 * BIT_CYC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_serial_in = 1'b1;
  logic [7:0] o_data_out;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         g_cyc = 0;
  int         busy_cnt = 0;
  logic [7:0] last_data = 8'h00;

  uart_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .i_serial_in (i_serial_in),
    .o_data_out  (o_data_out),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Look at the outputs settled from the previous rising edge
  task automatic observe();
    exp_t       e;
    logic [7:0] exp_data;
    if (o_busy) busy_cnt++;
    if (o_valid || o_frame_err) begin
      check("pulse_exclusive", 32'(o_valid & o_frame_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({o_valid, o_frame_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        exp_data = e.is_err ? last_data : e.data;
        check("pulse_kind", 32'(o_frame_err), 32'(e.is_err));
        check("pulse_cycle", 32'(g_cyc), 32'(e.cyc));
        check("data_out", 32'(o_data_out), 32'(exp_data));
        check("busy_at_pulse", 32'(o_busy), 32'd0);
        if (!e.is_err) last_data = e.data;
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    g_cyc++;
    observe();
    i_serial_in = b;
    rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic expect_pulse(input bit is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.cyc    = g_cyc + 1 + LAT;
    sb.push_back(e);
  endtask

  // Drive a frame bit-by-bit; glitch inverts the line at one cycle offset
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int glitch, input int nsteps);
    logic [9:0] fr;
    logic       b;
    fr = {stop_bit, d, 1'b0};
    for (int j = 0; j < nsteps; j++) begin
      b = fr[j / BIT_CYC];
      if (j == glitch) b = ~b;
      step(b, 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  32'(o_data_out), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_ferr"},  32'(o_frame_err), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] glitch_exp;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check_reset_values("reset");
    idle(20);

    expect_pulse(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, -1, FRAME_CYC);
    idle(20);

    // Back-to-back: second pulse stamp is FRAME_CYC after the first
    expect_pulse(1'b0, 8'h00);
    send_frame(8'h00, 1'b1, -1, FRAME_CYC);
    expect_pulse(1'b0, 8'hFF);
    send_frame(8'hFF, 1'b1, -1, FRAME_CYC);
    idle(20);

    busy_cnt = 0;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
    idle(300);
    check("glitch_busy_cycles", 32'(busy_cnt), 32'd80);
    check("glitch_idle_busy", 32'(o_busy), 32'd0);

    expect_pulse(1'b1, 8'h00);
    send_frame(8'h3C, 1'b0, -1, FRAME_CYC);
    idle(50);
    check("ferr_holds_data", 32'(o_data_out), 32'hFF);
    expect_pulse(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1, -1, FRAME_CYC);
    idle(20);

    expect_pulse(1'b1, 8'h00);
    for (int i = 0; i < 3000; i++) step(1'b0, 1'b0);
    idle(200);
    expect_pulse(1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1, -1, FRAME_CYC);
    idle(20);

    send_frame(8'h77, 1'b1, -1, 700);
    check("mid_data_busy", 32'(o_busy), 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    last_data = 8'h00;
    check_reset_values("midreset");
    idle(20);
    expect_pulse(1'b0, 8'h11);
    send_frame(8'h11, 1'b1, -1, FRAME_CYC);
    idle(20);

`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    expect_pulse(1'b0, glitch_exp);
    send_frame(8'h00, 1'b1, 80 + 4 * BIT_CYC, FRAME_CYC);
    idle(20);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) at a fixed baud rate derived from the system clock. It is the receive-side counterpart of the team's UART transmitter and carries host-to-chip bytes (keys, plaintext blocks) into the AES datapath. It delivers each correctly framed byte as a one-cycle valid pulse and flags stop-bit violations.

## Interface
- CLK_SPEED, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 625000, line bit rate
- COUNT_DIV, CLK_SPEED / BAUD_RATE (160), clock cycles per bit
- HALF_DIV, COUNT_DIV / 2 (80), cycles from start-bit detect to start-bit mid-point
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- serial_in  input  1  asynchronous UART line, idles high
- data_out  output  8  last correctly received byte, held until next good frame
- valid  output  1  one-cycle pulse, data_out updated this cycle
- frame_err  output  1  one-cycle pulse, stop bit sampled 0
- busy  output  1  high in any state other than IDLE

## Operation
- serial_in passes a 2-flop synchronizer; all decisions use the synchronized line rx_s.
- `armed` flag: cleared by reset and by frame error, set whenever rx_s = 1 in IDLE. A start is detected only while armed, so a held-low break yields exactly one frame_err.
- IDLE: if armed and rx_s = 0, go to START with counter = 0.
- START: counter increments; at counter = HALF_DIV-1, sample the line. If 0, go to DATA with counter = 0 and bit index = 0. If 1 (glitch), return to IDLE silently.
- DATA: counter 0..COUNT_DIV-1, wrapping to 0. At COUNT_DIV-1, shift the sample into the MSB of the shift register (right shift, so LSB-first data lands correctly) and increment the bit index. After bit index 7, go to STOP.
- STOP: at counter = COUNT_DIV-1, sample the line. If 1: data_out <= shift register and valid pulses. If 0: frame_err pulses, data_out is unchanged, and armed is cleared. In both cases go to IDLE.
- Counter is 10 bits wide; COUNT_DIV must be ≤ 1024 and ≥ 4.
- No backpressure. The consumer must capture data_out within one frame time. A new valid overwrites the previous byte.

## Timing
- Reset values: data_out = 0x00, valid = 0, frame_err = 0, busy = 0, state = IDLE, armed = 0, synchronizer flops = 1.
- Latency: valid/frame_err is high exactly 2 + HALF_DIV + 9·COUNT_DIV + 1 cycles after the first clock edge that samples serial_in low. With defaults, this is 1523.
- busy rises 1 cycle after rx_s goes low and falls in the cycle valid/frame_err is high.
- IDLE accepts a new start the cycle after STOP exits. Back-to-back frames from the transmitter are received with no gap loss.
- rst in any state returns to IDLE next cycle. A partial byte is discarded and no pulse is issued.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample point uses a 2-of-3 majority of rx_s at counter values N-2, N-1 and N. This adds no latency and rejects single-cycle glitches.
- Not defined: a single sample of rx_s at counter value N.

## Structure
- uart_pkg: state enum typedef for IDLE/START/DATA/STOP, the frame-length constant (8 data bits), and the idle line level. The package is shared with the transmitter.
- One sub-module, uart_rx_sync: 2-flop synchronizer with reset-to-1. When UART_RX_MAJORITY_EN is defined, it also provides a 3-deep sample history.

## Test plan
- Send 0xA5 at 160 cycles/bit → valid exactly once at cycle 1523, data_out = 0xA5, frame_err never asserted.
- Send 0x00 then 0xFF back-to-back with no idle gap → two valid pulses 1600 cycles apart, data_out = 0x00 then 0xFF.
- Drive serial_in low for 40 cycles, then high → no valid, no frame_err, busy high for about 80 cycles, then IDLE.
- Send 0x3C with stop bit 0 → frame_err pulse at cycle 1523, no valid, data_out keeps its previous value. Then 0x3C with a good stop → valid, data_out = 0x3C.
- Hold serial_in low for 3000 cycles, release, then send 0x5A → exactly one frame_err, then one valid with 0x5A.
- Assert rst at mid-DATA of 0x77, then send 0x11 → no pulse for 0x77, all outputs at reset values; valid with 0x11.
- UART_RX_MAJORITY_EN defined: 1-cycle high glitch at the bit-3 mid-point of 0x00 → data_out = 0x00. Macro undefined → data_out = 0x08.
